// File: rtl/sys_ctrl_rf.sv
// sys_ctrl_rf: UART command front-end that decodes 0xAA write / 0xBB read frames into register-file strobes.
// Optional build macro SYS_CTRL_TIMEOUT_EN enables an inter-byte timeout of TIMEOUT_CYCLES during partial frames.
module sys_ctrl_rf #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic                  WR_En,
  output logic                  RD_EN,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Vaild,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_FULL,
  output logic                  BUSY,
  output logic                  CMD_ERR
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_ADDR = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_TX_PUSH = 3'd5;

  localparam logic [DATA_WIDTH-1:0] OP_WRITE = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_READ  = DATA_WIDTH'(8'hBB);

  logic [2:0]            r_state;
  logic [DATA_WIDTH-1:0] r_addrByte;
  logic [DATA_WIDTH-1:0] r_resp;

  logic [2:0]            w_state;
  logic [DATA_WIDTH-1:0] w_addrByte;
  logic [DATA_WIDTH-1:0] w_resp;
  logic [ADDR_WIDTH-1:0] w_address;
  logic [DATA_WIDTH-1:0] w_wrData;
  logic                  w_wrEn;
  logic                  w_rdEn;
  logic [DATA_WIDTH-1:0] w_txData;
  logic                  w_txVld;
  logic                  w_cmdErr;

  // An address byte is legal only when no bit at or above ADDR_WIDTH is set.
  function automatic logic addrOk(input logic [DATA_WIDTH-1:0] a);
    return (a >> ADDR_WIDTH) == '0;
  endfunction

`ifdef SYS_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_tmoCnt;
  logic             w_timed;
  logic             w_timeout;

  assign w_timed   = (r_state == S_WR_ADDR) || (r_state == S_WR_DATA) || (r_state == S_RD_ADDR);
  assign w_timeout = w_timed && !RX_D_VLD && (r_tmoCnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_tmoCnt <= '0;
    end else if (RX_D_VLD || !w_timed || (w_state != r_state)) begin
      r_tmoCnt <= '0;
    end else begin
      r_tmoCnt <= r_tmoCnt + 1'b1;
    end
  end
`endif

  always_comb begin
    w_state    = r_state;
    w_addrByte = r_addrByte;
    w_resp     = r_resp;
    w_address  = Address;
    w_wrData   = WrData;
    w_wrEn     = 1'b0;
    w_rdEn     = 1'b0;
    w_txData   = TX_P_DATA;
    w_txVld    = 1'b0;
    w_cmdErr   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == OP_WRITE) begin
            w_state = S_WR_ADDR;
          end else if (RX_P_DATA == OP_READ) begin
            w_state = S_RD_ADDR;
          end else begin
            w_cmdErr = 1'b1;
          end
        end
      end

      S_WR_ADDR: begin
        if (RX_D_VLD) begin
          w_addrByte = RX_P_DATA;
          w_state    = S_WR_DATA;
        end
      end

      // Range is checked only here so an illegal write still consumes its data byte.
      S_WR_DATA: begin
        if (RX_D_VLD) begin
          if (addrOk(r_addrByte)) begin
            w_address = r_addrByte[ADDR_WIDTH-1:0];
            w_wrData  = RX_P_DATA;
            w_wrEn    = 1'b1;
          end else begin
            w_cmdErr = 1'b1;
          end
          w_state = S_IDLE;
        end
      end

      S_RD_ADDR: begin
        if (RX_D_VLD) begin
          if (addrOk(RX_P_DATA)) begin
            w_address = RX_P_DATA[ADDR_WIDTH-1:0];
            w_rdEn    = 1'b1;
            w_state   = S_RD_WAIT;
          end else begin
            w_cmdErr = 1'b1;
            w_state  = S_IDLE;
          end
        end
      end

      // Pushing straight from RdData keeps the N+3 response latency when TX has room.
      S_RD_WAIT: begin
        if (RX_D_VLD) begin
          w_cmdErr = 1'b1;
        end
        if (RdData_Vaild) begin
          w_resp = RdData;
          if (!TX_FULL) begin
            w_txData = RdData;
            w_txVld  = 1'b1;
            w_state  = S_IDLE;
          end else begin
            w_state = S_TX_PUSH;
          end
        end
      end

      S_TX_PUSH: begin
        if (RX_D_VLD) begin
          w_cmdErr = 1'b1;
        end
        if (!TX_FULL) begin
          w_txData = r_resp;
          w_txVld  = 1'b1;
          w_state  = S_IDLE;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

`ifdef SYS_CTRL_TIMEOUT_EN
    if (w_timeout) begin
      w_state  = S_IDLE;
      w_cmdErr = 1'b1;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_addrByte <= '0;
      r_resp     <= '0;
      Address    <= '0;
      WrData     <= '0;
      WR_En      <= 1'b0;
      RD_EN      <= 1'b0;
      TX_P_DATA  <= '0;
      TX_D_VLD   <= 1'b0;
      BUSY       <= 1'b0;
      CMD_ERR    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_addrByte <= w_addrByte;
      r_resp     <= w_resp;
      Address    <= w_address;
      WrData     <= w_wrData;
      WR_En      <= w_wrEn;
      RD_EN      <= w_rdEn;
      TX_P_DATA  <= w_txData;
      TX_D_VLD   <= w_txVld;
      BUSY       <= (w_state != S_IDLE);
      CMD_ERR    <= w_cmdErr;
    end
  end

endmodule

// File: doc/sys_ctrl_rf.md
# sys_ctrl_rf

Command front-end that sits directly upstream of the register file: it consumes bytes delivered by the UART receiver, decodes register write and register read frames, and drives the register file's Address, WrData, WR_En and RD_EN controls. Read data returned by the register file (RdData/RdData_Vaild) is pushed as one response byte into the UART transmit path.

## Interface
- DATA_WIDTH, 8: byte width of the UART and register-file data paths.
- ADDR_WIDTH, 4: register-file address width; legal addresses are 0 to 2^ADDR_WIDTH-1.
- TIMEOUT_CYCLES, 1024: inter-byte timeout in CLK cycles; used only with SYS_CTRL_TIMEOUT_EN.

- CLK  in  1  system clock; reset RST, asynchronous, active-low; clock CLK.
- RST  in  1  asynchronous active-low reset.
- RX_P_DATA  in  DATA_WIDTH  received byte, synchronous to CLK.
- RX_D_VLD  in  1  one-cycle pulse per received byte.
- Address  out  ADDR_WIDTH  register-file address.
- WrData  out  DATA_WIDTH  register-file write data.
- WR_En  out  1  register-file write strobe, one cycle.
- RD_EN  out  1  register-file read strobe, one cycle.
- RdData  in  DATA_WIDTH  register-file read data.
- RdData_Vaild  in  1  register-file read-data valid.
- TX_P_DATA  out  DATA_WIDTH  response byte to the TX path.
- TX_D_VLD  out  1  one-cycle push strobe to the TX path.
- TX_FULL  in  1  TX path cannot accept a byte.
- BUSY  out  1  high in every state except IDLE.
- CMD_ERR  out  1  one-cycle error pulse.

## Operation
- Frames: write is 0xAA, addr, data. Read is 0xBB, addr, and produces a 1-byte response.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_PUSH.
- IDLE:
  - RX 0xAA goes to WR_ADDR.
  - RX 0xBB goes to RD_ADDR.
  - Any other byte pulses CMD_ERR and stays in IDLE.
- WR_ADDR: the next byte is latched as the address, then the block goes to WR_DATA.
- WR_DATA:
  - On the next byte, drive WrData with that byte, Address with the latched address, and WR_En=1 for one cycle, then return to IDLE.
  - If the latched address was out of range (any bit at or above ADDR_WIDTH set), no WR_En is issued. CMD_ERR pulses instead and the block returns to IDLE.
- RD_ADDR:
  - A legal address drives Address and RD_EN=1 for one cycle, then the block goes to RD_WAIT.
  - An illegal address pulses CMD_ERR and the block returns to IDLE.
- RD_WAIT: on RdData_Vaild=1, capture RdData into the response register and go to TX_PUSH.
- TX_PUSH: when TX_FULL=0, drive TX_P_DATA with the response and TX_D_VLD=1 for one cycle, then return to IDLE. While TX_FULL=1, hold.
- Overrun: an RX_D_VLD received in RD_WAIT or TX_PUSH is dropped and pulses CMD_ERR. State is unaffected.
- WR_En and RD_EN are never high in the same cycle.
- All outputs are registered.
- Reset values: Address=0, WrData=0, WR_En=0, RD_EN=0, TX_P_DATA=0, TX_D_VLD=0, BUSY=0, CMD_ERR=0, state=IDLE.
- A reset asserted mid-frame aborts the frame. No strobe is issued after reset release until a new opcode arrives.

## Timing
- Write: the data byte's RX_D_VLD in cycle N gives WR_En=1 in cycle N+1.
- Read: the address byte's RX_D_VLD in cycle N gives:
  - RD_EN=1 in N+1;
  - RdData_Vaild=1 in N+2;
  - TX_D_VLD=1 in N+3 if TX_FULL=0.
- Each TX_FULL cycle adds one cycle of delay to TX_D_VLD.
- CMD_ERR is high the cycle after the offending RX_D_VLD.
- Back-to-back bytes on consecutive cycles are accepted in every state.

## Configuration
- SYS_CTRL_TIMEOUT_EN defined:
  - In WR_ADDR, WR_DATA and RD_ADDR, a counter clears on each RX_D_VLD and on state entry.
  - When the counter reaches TIMEOUT_CYCLES without a byte, CMD_ERR pulses, the block returns to IDLE, and no strobe is issued.
  - RD_WAIT and TX_PUSH are not timed.
- Not defined: there is no counter, and a partial frame waits indefinitely.

## Test plan
- Write path: RX 0xAA, 0x05, 0x3C, then RX 0xBB, 0x05 with TX_FULL=0.
  - WR_En=1 with Address=5, WrData=0x3C.
  - Then RD_EN=1 with Address=5, and TX_D_VLD=1 with TX_P_DATA=0x3C three cycles after the address byte.
- Unknown opcode: RX 0x11 gives CMD_ERR pulse, BUSY=0, and no WR_En/RD_EN.
- Out-of-range address: RX 0xAA, 0x20, 0x77 gives CMD_ERR after the data byte, no WR_En, and return to IDLE.
- Backpressure: RX 0xBB, 0x02 with TX_FULL=1 for 5 cycles gives TX_D_VLD only in the cycle after TX_FULL falls, with the captured value. An extra RX byte during the wait gives CMD_ERR with the response unchanged.
- Reset mid-frame: RX 0xAA, 0x01, then RST low.
  - All outputs return to 0.
  - A following byte 0x55 is treated as an opcode and gives CMD_ERR.
- With SYS_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16: RX 0xAA, then idle 16 cycles, gives CMD_ERR and IDLE. A later 0x99 gives CMD_ERR as an opcode, not as data.
